// File: rtl/vector_mem_arbiter.sv
// vector_mem_arbiter
//
// Shares the single external data memory port (req/gnt/rvalid protocol)
// between the scalar core LSU and the vector LSU. Each cycle one requester
// is selected and its request is forwarded combinationally to the data_*
// pins. The grant is routed back to the selected requester. The owner of
// every granted transaction is recorded in an in-order FIFO, so each
// returning rvalid/rdata reaches the requester that issued it.
//
// Parameters:
//   MAX_OUTSTANDING - granted-but-not-returned transactions allowed (1..4);
//                     this is also the owner FIFO depth
//   CNT_W           - width of the optional stall counters
//
// Ports:
//   clk, reset            - clock (rising edge), async active-high reset
//   core_*                - core LSU request side (req/gnt/rvalid, we/be/addr/wdata/rdata)
//   vlsu_*                - vector LSU request side, same set of signals
//   vlsu_lock_i           - the vector LSU owns the port exclusively
//   data_*                - external data memory port
//   busy_o                - at least one transaction is outstanding
//   err_o                 - sticky flag: an rvalid arrived with nothing outstanding
//   vlsu_stall_cnt_o      - vector LSU stall cycles (optional)
//   core_stall_cnt_o      - core stall cycles (optional)
//
// Optional feature macro: VECTOR_MEM_ARB_STALL_CNT_EN
//   When defined, saturating stall counters are built. When undefined, both
//   counter outputs are tied to zero and no counter flops exist.

module vector_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_req_i,
  output logic             core_gnt_o,
  output logic             core_rvalid_o,
  input  logic             core_we_i,
  input  logic [3:0]       core_be_i,
  input  logic [31:0]      core_addr_i,
  input  logic [31:0]      core_wdata_i,
  output logic [31:0]      core_rdata_o,
  input  logic             vlsu_req_i,
  output logic             vlsu_gnt_o,
  output logic             vlsu_rvalid_o,
  input  logic             vlsu_we_i,
  input  logic [3:0]       vlsu_be_i,
  input  logic [31:0]      vlsu_addr_i,
  input  logic [31:0]      vlsu_wdata_i,
  output logic [31:0]      vlsu_rdata_o,
  input  logic             vlsu_lock_i,
  output logic             data_req_o,
  input  logic             data_gnt_i,
  input  logic             data_rvalid_i,
  output logic             data_we_o,
  output logic [3:0]       data_be_o,
  output logic [31:0]      data_addr_o,
  output logic [31:0]      data_wdata_o,
  input  logic [31:0]      data_rdata_i,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] vlsu_stall_cnt_o,
  output logic [CNT_W-1:0] core_stall_cnt_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {OWNER_CORE = 1'b0, OWNER_VLSU = 1'b1} owner_t;

  owner_t          fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  owner_t          last_winner;
  logic            hold;
  owner_t          hold_owner;

  owner_t          owner;
  logic            winner_req;
  logic            fifo_full;
  logic            grant;
  logic            resp;
  owner_t          head;

  // Selection priority: a pending un-granted request must stay stable, then
  // the lock, then round-robin on contention, then the single requester.
  always_comb begin
    owner = OWNER_CORE;
    if (hold) begin
      owner = hold_owner;
    end else if (vlsu_lock_i) begin
      owner = OWNER_VLSU;
    end else if (core_req_i && vlsu_req_i) begin
      owner = (last_winner == OWNER_CORE) ? OWNER_VLSU : OWNER_CORE;
    end else if (vlsu_req_i) begin
      owner = OWNER_VLSU;
    end
  end

  assign winner_req = (owner == OWNER_VLSU) ? vlsu_req_i : core_req_i;
  assign fifo_full  = (count == CW'(MAX_OUTSTANDING));

  // Reset gating keeps the port quiet while reset is held, since reset is
  // asynchronous and the request path is purely combinational.
  assign data_req_o = winner_req && !fifo_full && !reset;
  assign grant      = data_req_o && data_gnt_i;
  assign resp       = data_rvalid_i && (count != '0) && !reset;
  assign head       = fifo_q[rd_ptr];

  assign data_we_o    = (owner == OWNER_VLSU) ? vlsu_we_i    : core_we_i;
  assign data_be_o    = (owner == OWNER_VLSU) ? vlsu_be_i    : core_be_i;
  assign data_addr_o  = (owner == OWNER_VLSU) ? vlsu_addr_i  : core_addr_i;
  assign data_wdata_o = (owner == OWNER_VLSU) ? vlsu_wdata_i : core_wdata_i;

  assign core_gnt_o    = grant && (owner == OWNER_CORE);
  assign vlsu_gnt_o    = grant && (owner == OWNER_VLSU);
  assign core_rvalid_o = resp && (head == OWNER_CORE);
  assign vlsu_rvalid_o = resp && (head == OWNER_VLSU);
  assign core_rdata_o  = data_rdata_i;
  assign vlsu_rdata_o  = data_rdata_i;

  assign busy_o = (count != '0);

  // Owner FIFO, round-robin history, request hold and the error flag.
  // A simultaneous push and pop leaves the count untouched while both
  // pointers advance, so ordering is preserved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= OWNER_CORE;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_winner <= OWNER_CORE;
      hold        <= 1'b0;
      hold_owner  <= OWNER_CORE;
      err_o       <= 1'b0;
    end else begin
      if (grant) begin
        fifo_q[wr_ptr] <= owner;
        wr_ptr         <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
        last_winner    <= owner;
      end
      if (resp) begin
        rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({grant, resp})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (grant) begin
        hold <= 1'b0;
      end else if (data_req_o) begin
        hold       <= 1'b1;
        hold_owner <= owner;
      end
      if (data_rvalid_i && (count == '0)) begin
        err_o <= 1'b1;
      end
    end
  end

`ifdef VECTOR_MEM_ARB_STALL_CNT_EN
  logic [CNT_W-1:0] core_stall_q;
  logic [CNT_W-1:0] vlsu_stall_q;

  // Saturating counts of cycles where a requester asks but is not granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_stall_q <= '0;
      vlsu_stall_q <= '0;
    end else begin
      if (core_req_i && !core_gnt_o && (core_stall_q != '1)) begin
        core_stall_q <= core_stall_q + 1'b1;
      end
      if (vlsu_req_i && !vlsu_gnt_o && (vlsu_stall_q != '1)) begin
        vlsu_stall_q <= vlsu_stall_q + 1'b1;
      end
    end
  end

  assign core_stall_cnt_o = core_stall_q;
  assign vlsu_stall_cnt_o = vlsu_stall_q;
`else
  assign core_stall_cnt_o = '0;
  assign vlsu_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Testbench for vector_mem_arbiter. Directed cycle-by-cycle stimulus pushes
// the expected grants and responses into scoreboard queues; a monitor
// process pops and compares whenever the DUT presents a grant or rvalid.

module tb_vector_mem_arbiter;

  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             core_req_i;
  logic             core_gnt_o;
  logic             core_rvalid_o;
  logic             core_we_i;
  logic [3:0]       core_be_i;
  logic [31:0]      core_addr_i;
  logic [31:0]      core_wdata_i;
  logic [31:0]      core_rdata_o;
  logic             vlsu_req_i;
  logic             vlsu_gnt_o;
  logic             vlsu_rvalid_o;
  logic             vlsu_we_i;
  logic [3:0]       vlsu_be_i;
  logic [31:0]      vlsu_addr_i;
  logic [31:0]      vlsu_wdata_i;
  logic [31:0]      vlsu_rdata_o;
  logic             vlsu_lock_i;
  logic             data_req_o;
  logic             data_gnt_i;
  logic             data_rvalid_i;
  logic             data_we_o;
  logic [3:0]       data_be_o;
  logic [31:0]      data_addr_o;
  logic [31:0]      data_wdata_o;
  logic [31:0]      data_rdata_i;
  logic             busy_o;
  logic             err_o;
  logic [CNT_W-1:0] vlsu_stall_cnt_o;
  logic [CNT_W-1:0] core_stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  // owner: 0 = core, 1 = vlsu; val: address for grants, rdata for responses
  typedef struct {
    logic        vlsu;
    logic [31:0] val;
  } exp_t;

  exp_t gnt_q[$];
  exp_t rsp_q[$];

  vector_mem_arbiter #(.MAX_OUTSTANDING(2), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .core_req_i       (core_req_i),
    .core_gnt_o       (core_gnt_o),
    .core_rvalid_o    (core_rvalid_o),
    .core_we_i        (core_we_i),
    .core_be_i        (core_be_i),
    .core_addr_i      (core_addr_i),
    .core_wdata_i     (core_wdata_i),
    .core_rdata_o     (core_rdata_o),
    .vlsu_req_i       (vlsu_req_i),
    .vlsu_gnt_o       (vlsu_gnt_o),
    .vlsu_rvalid_o    (vlsu_rvalid_o),
    .vlsu_we_i        (vlsu_we_i),
    .vlsu_be_i        (vlsu_be_i),
    .vlsu_addr_i      (vlsu_addr_i),
    .vlsu_wdata_i     (vlsu_wdata_i),
    .vlsu_rdata_o     (vlsu_rdata_o),
    .vlsu_lock_i      (vlsu_lock_i),
    .data_req_o       (data_req_o),
    .data_gnt_i       (data_gnt_i),
    .data_rvalid_i    (data_rvalid_i),
    .data_we_o        (data_we_o),
    .data_be_o        (data_be_o),
    .data_addr_o      (data_addr_o),
    .data_wdata_o     (data_wdata_o),
    .data_rdata_i     (data_rdata_i),
    .busy_o           (busy_o),
    .err_o            (err_o),
    .vlsu_stall_cnt_o (vlsu_stall_cnt_o),
    .core_stall_cnt_o (core_stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared compare-and-report helper
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, set the per-cycle inputs,
  // then let combinational outputs settle
  task automatic applyStimulus(input logic creq, input logic vreq, input logic lock,
                               input logic gnt, input logic rvld, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    core_req_i    = creq;
    vlsu_req_i    = vreq;
    vlsu_lock_i   = lock;
    data_gnt_i    = gnt;
    data_rvalid_i = rvld;
    data_rdata_i  = rdata;
    #1;
  endtask

  task automatic expGnt(input logic vlsu, input logic [31:0] addr);
    exp_t e;
    e.vlsu = vlsu;
    e.val  = addr;
    gnt_q.push_back(e);
  endtask

  task automatic expRsp(input logic vlsu, input logic [31:0] rdata);
    exp_t e;
    e.vlsu = vlsu;
    e.val  = rdata;
    rsp_q.push_back(e);
  endtask

  // Monitor: compare each presented grant / response against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (core_gnt_o || vlsu_gnt_o) begin
        if (gnt_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_gnt actual=%b%b expected=none", vlsu_gnt_o, core_gnt_o);
        end else begin
          exp_t e;
          e = gnt_q.pop_front();
          checkOutput("gnt_owner", {30'd0, vlsu_gnt_o, core_gnt_o}, e.vlsu ? 32'd2 : 32'd1);
          checkOutput("gnt_addr", data_addr_o, e.val);
          checkOutput("gnt_be", {28'd0, data_be_o}, e.vlsu ? 32'h3 : 32'hF);
        end
      end
      if (core_rvalid_o || vlsu_rvalid_o) begin
        if (rsp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rvalid actual=%b%b expected=none", vlsu_rvalid_o, core_rvalid_o);
        end else begin
          exp_t e;
          e = rsp_q.pop_front();
          checkOutput("rvalid_owner", {30'd0, vlsu_rvalid_o, core_rvalid_o}, e.vlsu ? 32'd2 : 32'd1);
          checkOutput("rdata", e.vlsu ? vlsu_rdata_o : core_rdata_o, e.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    core_req_i    = 1'b1;
    vlsu_req_i    = 1'b0;
    vlsu_lock_i   = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    core_we_i     = 1'b0;
    core_be_i     = 4'hF;
    core_addr_i   = 32'h100;
    core_wdata_i  = 32'h1111_1111;
    vlsu_we_i     = 1'b1;
    vlsu_be_i     = 4'h3;
    vlsu_addr_i   = 32'h300;
    vlsu_wdata_i  = 32'h2222_2222;

    // Reset state: everything quiet even with a request pending
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_data_req", {31'd0, data_req_o}, 32'd0);
    checkOutput("reset_core_gnt", {31'd0, core_gnt_o}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset_err", {31'd0, err_o}, 32'd0);
    checkOutput("reset_stall_cnt", {16'd0, core_stall_cnt_o}, 32'd0);
    reset = 1'b0;

    // Core read alone, grant after two wait cycles
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("core_alone_req", {31'd0, data_req_o}, 32'd1);
    checkOutput("core_alone_addr", data_addr_o, 32'h100);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("core_alone_wait_gnt", {31'd0, core_gnt_o}, 32'd0);
    expGnt(0, 32'h100);
    applyStimulus(1, 0, 0, 1, 0, 0);
    expRsp(0, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 1, 32'hDEADBEEF);
    checkOutput("core_alone_vlsu_rvalid", {31'd0, vlsu_rvalid_o}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("core_alone_busy_after", {31'd0, busy_o}, 32'd0);

    // Hold: core stalled, VLSU rises (would win round-robin), core must stay
    core_addr_i = 32'h400;
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("hold_addr_1", data_addr_o, 32'h400);
    checkOutput("hold_vlsu_gnt_1", {31'd0, vlsu_gnt_o}, 32'd0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("hold_addr_2", data_addr_o, 32'h400);
    expGnt(0, 32'h400);
    applyStimulus(1, 1, 0, 1, 0, 0);
    expGnt(1, 32'h300);
    expRsp(0, 32'h0000_00B0);
    applyStimulus(0, 1, 0, 1, 1, 32'h0000_00B0);
    expRsp(1, 32'h0000_00B1);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_00B1);

    // Contention: last winner is VLSU, so alternation starts with the core
    core_addr_i = 32'h200;
    expGnt(0, 32'h200);
    applyStimulus(1, 1, 0, 1, 0, 0);
    expGnt(1, 32'h300);
    expRsp(0, 32'h0000_00A1);
    applyStimulus(1, 1, 0, 1, 1, 32'h0000_00A1);
    expGnt(0, 32'h200);
    expRsp(1, 32'h0000_00A2);
    applyStimulus(1, 1, 0, 1, 1, 32'h0000_00A2);
    expGnt(1, 32'h300);
    expRsp(0, 32'h0000_00A3);
    applyStimulus(1, 1, 0, 1, 1, 32'h0000_00A3);
    expRsp(1, 32'h0000_00A4);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_00A4);

    // Lock: a core transfer already outstanding still returns to the core
    expGnt(0, 32'h200);
    applyStimulus(1, 0, 0, 1, 0, 0);
    expGnt(1, 32'h300);
    expRsp(0, 32'h0000_00D0);
    applyStimulus(1, 1, 1, 1, 1, 32'h0000_00D0);
    checkOutput("lock_core_gnt_1", {31'd0, core_gnt_o}, 32'd0);
    expGnt(1, 32'h300);
    expRsp(1, 32'h0000_00D1);
    applyStimulus(1, 1, 1, 1, 1, 32'h0000_00D1);
    checkOutput("lock_core_gnt_2", {31'd0, core_gnt_o}, 32'd0);
    expGnt(1, 32'h300);
    expRsp(1, 32'h0000_00D2);
    applyStimulus(1, 1, 1, 1, 1, 32'h0000_00D2);
    expRsp(1, 32'h0000_00D3);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_00D3);
`ifndef VECTOR_MEM_ARB_STALL_CNT_EN
    checkOutput("stall_cnt_tied", {16'd0, core_stall_cnt_o}, 32'd0);
`endif

    // Full FIFO: two grants with no response block further requests
    core_addr_i = 32'h500;
    expGnt(0, 32'h500);
    applyStimulus(1, 0, 0, 1, 0, 0);
    expGnt(0, 32'h500);
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("full_data_req", {31'd0, data_req_o}, 32'd0);
    checkOutput("full_busy", {31'd0, busy_o}, 32'd1);
    expRsp(0, 32'h0000_00E0);
    applyStimulus(1, 0, 0, 1, 1, 32'h0000_00E0);
    checkOutput("full_no_bypass", {31'd0, data_req_o}, 32'd0);
    expGnt(0, 32'h500);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("full_reissue", {31'd0, data_req_o}, 32'd1);
    expRsp(0, 32'h0000_00E1);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_00E1);
    expRsp(0, 32'h0000_00E2);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_00E2);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("full_drained_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("err_before_spurious", {31'd0, err_o}, 32'd0);

    // Spurious rvalid with nothing outstanding
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_0BAD);
    checkOutput("spurious_no_rvalid", {30'd0, vlsu_rvalid_o, core_rvalid_o}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("spurious_err", {31'd0, err_o}, 32'd1);

    // Reset with one transaction outstanding
    expGnt(0, 32'h500);
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("pre_reset_busy", {31'd0, busy_o}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("mid_reset_err", {31'd0, err_o}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_0CAF);
    checkOutput("post_reset_no_rvalid", {30'd0, vlsu_rvalid_o, core_rvalid_o}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Every expected grant and response must have been consumed
    @(negedge clk);
    checkOutput("gnt_queue_empty", gnt_q.size(), 32'd0);
    checkOutput("rsp_queue_empty", rsp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
